vga_layer_compositor: RTL
=========================

VGA_LAYER_COMPOSITOR -- requirements
Module: vga_layer_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 2, number of sprite layers; legal range 1..4.
REQ-002 Parameter TRANSPARENT_KEY, default 12'hF0F, layer colour treated as "not drawn".
REQ-003 Parameter GROUND_Y, default 10'd360, scanline drawn as ground.
REQ-004 Parameter GROUND_RGB, default 12'h0F0; parameter BG_RGB, default 12'h000.
REQ-005 Parameter SYNC_IDLE, default 1'b1, inactive level of hsync/vsync.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 pix_en  in  1  pixel strobe; the pipeline advances only when it is high.
REQ-009 hcount, vcount  in  10 each  pixel coordinates from the timing generator.
REQ-010 visible, hsync_in, vsync_in  in  1 each  timing generator outputs.
REQ-011 layer_on  in  NUM_LAYERS  per-layer pixel-hit flag.
REQ-012 layer_rgb  in  NUM_LAYERS*12  per-layer colour; layer i occupies bits [12i+11:12i].
REQ-013 prio_wr  in  1  write strobe for prio_in.
REQ-014 prio_in  in  NUM_LAYERS*2  per-layer rank; 0 is frontmost.
REQ-015 hsync_out, vsync_out  out  1 each  syncs delayed to match the colour outputs.
REQ-016 vga_r, vga_g, vga_b  out  4 each  composited colour.
REQ-017 collide_mask  out  NUM_LAYERS  layers that overlapped during the previous frame.
REQ-018 collide_pulse  out  1  one-clk pulse at a frame boundary when the previous frame had a collision.
REQ-019 collide_count  out  8  count of collision frames, saturating.

Function
REQ-020 The pipeline has 2 stages, both advancing only on pix_en.
- Stage 1 registers all pixel inputs.
- Stage 2 registers the resolved colour and the syncs.
- Latency is exactly 2 pix_en strobes for colour, hsync and vsync.
REQ-021 A layer is opaque when its layer_on is 1 and its layer_rgb is not equal to TRANSPARENT_KEY.
REQ-022 The winner SHALL be the opaque layer with the lowest active rank; on equal ranks, the lowest index wins.
REQ-023 If no layer is opaque, the output colour is GROUND_RGB when vcount==GROUND_Y, otherwise BG_RGB.
REQ-024 When the stage-1 visible bit is 0, the output colour is 12'h000, regardless of layers.
REQ-025 prio_in is captured into a shadow register on prio_wr. The shadow is copied to the active ranks only at a frame start (stage-1 hcount==0 && vcount==0 with pix_en). Ranks therefore never change mid-frame.
REQ-026 Several prio_wr pulses within one frame: the last written value wins at the next frame start.
REQ-027 A collision pixel has visible high and at least 2 opaque layers. Every opaque layer at that pixel is ORed into a per-frame accumulator.
REQ-028 At a frame start, in the same clock:
- collide_mask <= accumulator.
- collide_pulse = 1 if the accumulator is non-zero.
- collide_count increments if the accumulator is non-zero, saturating at 8'd255.
- The accumulator reloads with only the frame-start pixel's own collision bits.
REQ-029 collide_pulse SHALL be high for exactly one clk cycle, independent of pix_en width.
REQ-030 With NUM_LAYERS==1, collision logic is constant zero and the winner is layer 0 when opaque.

Reset
REQ-031 While reset_n is low, asynchronously:
- all pipeline registers and vga_r/g/b = 0;
- hsync_out = vsync_out = SYNC_IDLE;
- collide_mask, accumulator, collide_pulse, collide_count = 0;
- active and shadow rank of layer i = i (mod 4).
REQ-032 Reset deasserted mid-frame: the partial frame's collisions are accumulated normally and reported at the next frame start. The first 2 pix_en strobes output the reset colour 0.

Verification
REQ-033 Layer0 opaque 12'hF00 and layer1 opaque 12'h00F at the same pixel, default ranks → output F,0,0 two strobes later; swap ranks via prio_wr → change takes effect on the next frame, not the current one.
REQ-034 Layer0 on with rgb=12'hF0F and layer1 off, at vcount=360 → output 0,F,0 (ground); at vcount=100 → 0,0,0.
REQ-035 Overlap of layers 0 and 1 for 1 pixel in frame N → at the start of frame N+1: collide_mask=2'b11, collide_pulse high for 1 clk, collide_count=1; frame N+1 with no overlap → mask 0 at frame N+2 and count stays 1.
REQ-036 Collisions in 300 consecutive frames → collide_count = 255 and holds.
REQ-037 Layers opaque while visible=0 → colour 0 and no collision recorded; hsync_in toggles → hsync_out follows exactly 2 strobes later.
REQ-038 Assert reset_n=0 mid-frame with count=5 → outputs clear immediately without waiting for clk; ranks return to index order.

Source files
------------

// File: rtl/vga_layer_compositor.sv
// Two-stage VGA sprite compositor.
// Stage 1 registers the raw pixel inputs; stage 2 registers the resolved
// colour and the delayed syncs. Each layer carries a 2-bit rank (0 is
// frontmost). Ranks are written into a shadow copy at any time and become
// active only at a frame start, so a frame is always drawn with one ranking.
// Pixels where two or more visible layers are opaque are collected per frame
// and reported at the following frame start.
//
// Handshake: there is no valid/ready pair. pix_en is a qualifier: a clock edge
// with pix_en high moves one pixel through both stages; with pix_en low every
// pixel register holds. prio_wr is sampled on every clock edge, regardless of
// pix_en.
module vga_layer_compositor #(
    parameter int          NUM_LAYERS      = 2,
    parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F,
    parameter logic [9:0]  GROUND_Y        = 10'd360,
    parameter logic [11:0] GROUND_RGB      = 12'h0F0,
    parameter logic [11:0] BG_RGB          = 12'h000,
    parameter logic        SYNC_IDLE       = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pix_en,
    input  logic [9:0]                hcount,
    input  logic [9:0]                vcount,
    input  logic                      visible,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [NUM_LAYERS-1:0]     layer_on,
    input  logic [NUM_LAYERS*12-1:0]  layer_rgb,
    input  logic                      prio_wr,
    input  logic [NUM_LAYERS*2-1:0]   prio_in,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic [3:0]                vga_r,
    output logic [3:0]                vga_g,
    output logic [3:0]                vga_b,
    output logic [NUM_LAYERS-1:0]     collide_mask,
    output logic                      collide_pulse,
    output logic [7:0]                collide_count
);

    // Reset ranking: layer i gets rank i (mod 4), i.e. index order.
    function automatic logic [NUM_LAYERS*2-1:0] index_ranks();
        logic [NUM_LAYERS*2-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            r[2*i +: 2] = 2'(i % 4);
        end
        return r;
    endfunction

    localparam logic [NUM_LAYERS*2-1:0] RESET_RANKS = index_ranks();

    // Stage 1: raw pixel inputs
    logic                     s1_visible_q;
    logic                     s1_hsync_q;
    logic                     s1_vsync_q;
    logic [9:0]               s1_hcount_q;
    logic [9:0]               s1_vcount_q;
    logic [NUM_LAYERS-1:0]    s1_on_q;
    logic [NUM_LAYERS*12-1:0] s1_rgb_q;

    // Stage 2: resolved colour and delayed syncs
    logic [11:0]              colour_q;
    logic [11:0]              colour_d;
    logic                     hsync_q;
    logic                     vsync_q;

    // Rank storage
    logic [NUM_LAYERS*2-1:0]  shadow_rank_q;
    logic [NUM_LAYERS*2-1:0]  active_rank_q;
    logic [NUM_LAYERS*2-1:0]  eff_rank;

    // Collision tracking
    logic [NUM_LAYERS-1:0]    acc_q;
    logic [NUM_LAYERS-1:0]    acc_d;
    logic [NUM_LAYERS-1:0]    mask_q;
    logic [NUM_LAYERS-1:0]    mask_d;
    logic                     pulse_q;
    logic                     pulse_d;
    logic [7:0]               count_q;
    logic [7:0]               count_d;

    // Per-pixel decode of stage 1
    logic [NUM_LAYERS-1:0]    s1_opaque;
    logic [2:0]               n_opaque;
    logic [NUM_LAYERS-1:0]    collide_hits;
    logic                     frame_start;
    logic                     win_found;
    logic [1:0]               win_rank;
    logic [11:0]              win_rgb;

    // The pixel sitting in stage 1 is (0,0) and is being consumed this edge.
    assign frame_start = pix_en && (s1_hcount_q == 10'd0) && (s1_vcount_q == 10'd0);

    // The frame-start pixel itself is drawn with the ranking that becomes
    // active on this edge, so a whole frame uses one ranking.
    assign eff_rank = frame_start ? shadow_rank_q : active_rank_q;

    // Opaque decode and opaque-layer count for the stage-1 pixel
    always_comb begin
        s1_opaque = '0;
        n_opaque  = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_opaque[i] = s1_on_q[i] && (s1_rgb_q[12*i +: 12] != TRANSPARENT_KEY);
            n_opaque     = n_opaque + 3'(s1_opaque[i]);
        end
    end

    // Collision bits of the stage-1 pixel; a single layer can never collide
    always_comb begin
        collide_hits = '0;
        if (NUM_LAYERS >= 2 && s1_visible_q && (n_opaque >= 3'd2)) begin
            collide_hits = s1_opaque;
        end
    end

    // Winner search: strictly lower rank replaces, so ties keep the lower index
    always_comb begin
        win_found = 1'b0;
        win_rank  = 2'd0;
        win_rgb   = 12'h000;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (s1_opaque[i] && (!win_found || (eff_rank[2*i +: 2] < win_rank))) begin
                win_found = 1'b1;
                win_rank  = eff_rank[2*i +: 2];
                win_rgb   = s1_rgb_q[12*i +: 12];
            end
        end
    end

    // Final colour: blanking beats layers, layers beat ground/background
    always_comb begin
        colour_d = 12'h000;
        if (!s1_visible_q) begin
            colour_d = 12'h000;
        end else if (win_found) begin
            colour_d = win_rgb;
        end else if (s1_vcount_q == GROUND_Y) begin
            colour_d = GROUND_RGB;
        end else begin
            colour_d = BG_RGB;
        end
    end

    // Collision accumulator, frame report, one-clock pulse and saturating count
    always_comb begin
        acc_d   = acc_q;
        mask_d  = mask_q;
        pulse_d = 1'b0;
        count_d = count_q;
        if (frame_start) begin
            mask_d  = acc_q;
            pulse_d = |acc_q;
            if ((|acc_q) && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
            end
            acc_d = collide_hits;
        end else if (pix_en) begin
            acc_d = acc_q | collide_hits;
        end
    end

    // Stage 1 register: capture the incoming pixel on each strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_visible_q <= 1'b0;
            s1_hsync_q   <= SYNC_IDLE;
            s1_vsync_q   <= SYNC_IDLE;
            s1_hcount_q  <= '0;
            s1_vcount_q  <= '0;
            s1_on_q      <= '0;
            s1_rgb_q     <= '0;
        end else if (pix_en) begin
            s1_visible_q <= visible;
            s1_hsync_q   <= hsync_in;
            s1_vsync_q   <= vsync_in;
            s1_hcount_q  <= hcount;
            s1_vcount_q  <= vcount;
            s1_on_q      <= layer_on;
            s1_rgb_q     <= layer_rgb;
        end
    end

    // Stage 2 register: resolved colour and syncs, aligned to each other
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            colour_q <= 12'h000;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
        end else if (pix_en) begin
            colour_q <= colour_d;
            hsync_q  <= s1_hsync_q;
            vsync_q  <= s1_vsync_q;
        end
    end

    // Rank registers: shadow on every write, active only at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_rank_q <= RESET_RANKS;
            active_rank_q <= RESET_RANKS;
        end else begin
            if (prio_wr) begin
                shadow_rank_q <= prio_in;
            end
            if (frame_start) begin
                active_rank_q <= shadow_rank_q;
            end
        end
    end

    // Collision state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            mask_q  <= '0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    assign vga_r         = colour_q[11:8];
    assign vga_g         = colour_q[7:4];
    assign vga_b         = colour_q[3:0];
    assign hsync_out     = hsync_q;
    assign vsync_out     = vsync_q;
    assign collide_mask  = mask_q;
    assign collide_pulse = pulse_q;
    assign collide_count = count_q;

endmodule
